// File: rtl/mem_stage_unit.sv
// mem_stage_unit: issues one load/store per start to the data cache and returns an
// aligned, extended load result with a single-cycle completion pulse.
module mem_stage_unit #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memory_enable,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   alu_data,
    input  logic [XLEN-1:0]     reg_b_contents,
    output logic [XLEN-1:0]     loaded_data_out,
    output logic                memory_done,
    output logic                access_err,
    output logic                dc_req_valid,
    input  logic                dc_req_ready,
    output logic                dc_req_write,
    output logic [ADDR_W-1:0]   dc_req_addr,
    output logic [XLEN-1:0]     dc_req_wdata,
    output logic [XLEN/8-1:0]   dc_req_wstrb,
    input  logic                dc_resp_valid,
    input  logic [XLEN-1:0]     dc_resp_rdata
);
    localparam int BW = XLEN / 8;
    localparam int LB = $clog2(BW);
    localparam int SW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                state, state_n;
    logic [LB-1:0]         lane, lane_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [3:0]            nb;
    logic                  mem_op, illegal;
    logic [15:0]           strb_m;
    logic [SW-1:0]         k;
    logic [XLEN-1:0]       shifted, zx, load_val;
    logic signed [XLEN-1:0] top, sx;

    assign dc_req_valid = state == REQ;
    assign memory_done  = state == DONE;

    always_comb begin
        lane     = alu_data[LB-1:0];
        nb       = 4'd1 << funct3[1:0];
        mem_op   = mem_read | mem_write;
        illegal  = (mem_read & mem_write) | (XLEN == 32 && funct3[1:0] == 2'd3) |
                   (|(alu_data[2:0] & 3'(nb - 4'd1)));
        strb_m   = (16'd1 << nb) - 16'd1;
        // Left-justify the selected field, then shift back to extend it.
        k        = SW'(XLEN) - (SW'(8) << size_q);
        shifted  = dc_resp_rdata >> {lane_q, 3'b000};
        top      = shifted << k;
        sx       = top >>> k;
        zx       = top >> k;
        load_val = uns_q ? zx : sx;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (memory_enable) state_n = (!mem_op || illegal) ? DONE : REQ;
            REQ:     if (dc_req_ready) state_n = WAIT;
            WAIT:    if (dc_resp_valid) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            lane_q          <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            dc_req_write    <= 1'b0;
            dc_req_addr     <= '0;
            dc_req_wdata    <= '0;
            dc_req_wstrb    <= '0;
            loaded_data_out <= '0;
            access_err      <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && memory_enable) begin
                if (!mem_op || illegal) begin
                    loaded_data_out <= '0;
                    access_err      <= mem_op;
                end else begin
                    lane_q       <= lane;
                    size_q       <= funct3[1:0];
                    uns_q        <= funct3[2];
                    dc_req_write <= mem_write;
                    dc_req_addr  <= {alu_data[ADDR_W-1:LB], LB'(0)};
                    dc_req_wdata <= mem_write ? reg_b_contents << {lane, 3'b000} : '0;
                    dc_req_wstrb <= mem_write ? BW'(strb_m << lane) : '0;
                end
            end
            if (state == WAIT && dc_resp_valid) begin
                loaded_data_out <= dc_req_write ? '0 : load_val;
                access_err      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: vector table, reset sequences and randomized ops checked against
// a byte-level reference model; a 32-bit instance covers the doubleword error case.
module tb_mem_stage_unit;
    logic        clk = 1'b0;
    logic        reset, memory_enable, mem_read, mem_write, dc_req_ready, dc_resp_valid;
    logic [2:0]  funct3;
    logic [63:0] alu_data, reg_b_contents, dc_resp_rdata;
    logic [63:0] loaded_data_out, dc_req_addr, dc_req_wdata;
    logic [7:0]  dc_req_wstrb;
    logic        memory_done, access_err, dc_req_valid, dc_req_write;
    logic [31:0] w_ld, w_wdata;
    logic [63:0] w_addr;
    logic [3:0]  w_wstrb;
    logic        w_done, w_err, w_valid, w_write;
    int          pass_cnt = 0, total_cnt = 0;

    typedef struct {
        logic        rd, wr, pulse;
        logic [2:0]  f3;
        logic [63:0] addr, regb, rdata;
        int          rdly, sdly, e_done;
        logic [63:0] e_ld, e_addr, e_wdata;
        logic        e_err;
        logic [7:0]  e_wstrb;
    } vec_t;

    mem_stage_unit #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .memory_enable(memory_enable), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .alu_data(alu_data),
        .reg_b_contents(reg_b_contents), .loaded_data_out(loaded_data_out),
        .memory_done(memory_done), .access_err(access_err), .dc_req_valid(dc_req_valid),
        .dc_req_ready(dc_req_ready), .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata)
    );

    mem_stage_unit #(.XLEN(32), .ADDR_W(64)) dut32 (
        .clk(clk), .reset(reset), .memory_enable(memory_enable), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .alu_data(alu_data),
        .reg_b_contents(reg_b_contents[31:0]), .loaded_data_out(w_ld),
        .memory_done(w_done), .access_err(w_err), .dc_req_valid(w_valid),
        .dc_req_ready(dc_req_ready), .dc_req_write(w_write), .dc_req_addr(w_addr),
        .dc_req_wdata(w_wdata), .dc_req_wstrb(w_wstrb),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata[31:0])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic rd, wr, input logic [2:0] f3,
                                input logic [63:0] addr, regb, rdata, input int rdly, sdly,
                                input logic pulse, input int e_done, input logic [63:0] e_ld,
                                input logic e_err, input logic [63:0] e_addr, e_wdata,
                                input logic [7:0] e_wstrb);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.regb = regb; v.rdata = rdata;
        v.rdly = rdly; v.sdly = sdly; v.pulse = pulse; v.e_done = e_done; v.e_ld = e_ld;
        v.e_err = e_err; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
        return v;
    endfunction

    // Reference: byte-by-byte gather and explicit extension for a 64-bit datapath.
    function automatic vec_t model(input logic rd, wr, input logic [2:0] f3,
                                   input logic [63:0] addr, regb, rdata,
                                   input int rdly, sdly, input logic pulse);
        int nb = 1 << f3[1:0];
        int lane = int'(addr[2:0]);
        logic err = (rd && wr) || (lane % nb != 0);
        logic [63:0] ld = '0;
        logic [7:0] st = '0;
        if (rd && !wr && !err) begin
            for (int i = 0; i < nb; i++) ld[i*8 +: 8] = rdata[(lane+i)*8 +: 8];
            if (!f3[2] && ld[nb*8-1])
                for (int i = nb*8; i < 64; i++) ld[i] = 1'b1;
        end
        if (wr) for (int i = 0; i < nb; i++) st[lane+i] = 1'b1;
        return mk(rd, wr, f3, addr, regb, rdata, rdly, sdly, pulse,
                  (!(rd || wr) || err) ? 1 : rdly + sdly + 2, ld, (rd || wr) && err,
                  addr & ~64'h7, regb << (lane * 8), st);
    endfunction

    task automatic run(input vec_t v);
        int cyc = 0, vcnt = 0, acc = -1, d32 = -1, v32 = 0;
        logic stable = 1'b1, e32 = 1'b0, fwr = 1'b0;
        logic [63:0] fa = '0, fw = '0;
        logic [7:0] fs = '0;
        @(negedge clk);
        mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; alu_data = v.addr;
        reg_b_contents = v.regb; memory_enable = 1'b1; dc_req_ready = 1'b0;
        dc_resp_valid = 1'b1; dc_resp_rdata = ~v.rdata;
        while (1) begin
            @(negedge clk);
            cyc++;
            memory_enable = v.pulse && cyc == 2;
            if (w_valid) v32++;
            if (w_done && d32 < 0) begin d32 = cyc; e32 = w_err; end
            if (dc_req_valid) begin
                if (vcnt == 0) begin
                    fa = dc_req_addr; fw = dc_req_wdata; fs = dc_req_wstrb; fwr = dc_req_write;
                end else if ({fa, fw, fs, fwr} !== {dc_req_addr, dc_req_wdata, dc_req_wstrb, dc_req_write})
                    stable = 1'b0;
                vcnt++;
            end
            if (memory_done || cyc >= 60) break;
            dc_req_ready  = dc_req_valid && vcnt > v.rdly;
            if (dc_req_ready) acc = cyc;
            dc_resp_valid = !(acc >= 0 && cyc > acc && cyc < acc + v.sdly);
            dc_resp_rdata = (acc >= 0 && cyc == acc + v.sdly) ? v.rdata : ~v.rdata;
        end
        memory_enable = 1'b0; dc_req_ready = 1'b0;
        chk("done_cycle", 64'(cyc), 64'(v.e_done));
        chk("access_err", {63'b0, access_err}, {63'b0, v.e_err});
        chk("load_data", loaded_data_out, v.e_ld);
        if (v.e_done > 1) begin
            chk("req_addr", fa, v.e_addr);
            chk("req_wstrb", {56'b0, fs}, {56'b0, v.e_wstrb});
            chk("req_write", {63'b0, fwr}, {63'b0, v.wr});
            chk("req_stable", {63'b0, stable}, 64'd1);
            if (v.wr) chk("req_wdata", fw, v.e_wdata);
        end else
            chk("no_request", 64'(vcnt), 64'd0);
        if (v.f3[1:0] == 2'd3 && v.rd != v.wr) begin
            chk("x32_done_cycle", 64'(d32), 64'd1);
            chk("x32_err_noreq", {62'b0, e32, v32 == 0}, 64'd3);
        end
        @(negedge clk);
        chk("idle_after", {62'b0, memory_done, dc_req_valid}, 64'd0);
        chk("load_hold", loaded_data_out, v.e_ld);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ld"}, loaded_data_out, 64'd0);
        chk({tag, "_ctl"}, {60'b0, dc_req_valid, dc_req_write, memory_done, access_err}, 64'd0);
        chk({tag, "_req"}, dc_req_addr | dc_req_wdata | {56'b0, dc_req_wstrb}, 64'd0);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = mk(1, 0, 3'd0, 64'h1003, 64'h0, 64'h1122_3344_8566_7788, 0, 1, 0,
                      3, 64'hFFFF_FFFF_FFFF_FF85, 0, 64'h1000, 64'h0, 8'h00);
        vecs[1]  = mk(1, 0, 3'd4, 64'h1003, 64'h0, 64'h1122_3344_8566_7788, 0, 1, 0,
                      3, 64'h85, 0, 64'h1000, 64'h0, 8'h00);
        vecs[2]  = mk(0, 1, 3'd1, 64'h2006, 64'hABCD, 64'h0, 0, 1, 0,
                      3, 64'h0, 0, 64'h2000, 64'hABCD_0000_0000_0000, 8'hC0);
        vecs[3]  = mk(1, 0, 3'd2, 64'h3002, 64'h0, 64'h0, 0, 1, 0,
                      1, 64'h0, 1, 64'h0, 64'h0, 8'h00);
        vecs[4]  = mk(1, 1, 3'd0, 64'h10, 64'h55, 64'h0, 0, 1, 0,
                      1, 64'h0, 1, 64'h0, 64'h0, 8'h00);
        vecs[5]  = mk(1, 0, 3'd3, 64'h4000, 64'h0, 64'h8123_4567_89AB_CDEF, 4, 3, 1,
                      9, 64'h8123_4567_89AB_CDEF, 0, 64'h4000, 64'h0, 8'h00);
        vecs[6]  = mk(0, 0, 3'd2, 64'h7, 64'h0, 64'h0, 0, 1, 0,
                      1, 64'h0, 0, 64'h0, 64'h0, 8'h00);
        vecs[7]  = mk(0, 1, 3'd2, 64'h5004, 64'hFFFF_FFFF_1234_5678, 64'h0, 1, 2, 0,
                      5, 64'h0, 0, 64'h5000, 64'h1234_5678_0000_0000, 8'hF0);
        vecs[8]  = mk(1, 0, 3'd1, 64'h6006, 64'h0, 64'h8001_0000_0000_0000, 0, 1, 0,
                      3, 64'hFFFF_FFFF_FFFF_8001, 0, 64'h6000, 64'h0, 8'h00);
        vecs[9]  = mk(1, 0, 3'd2, 64'h8, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 1, 0,
                      3, 64'hFFFF_FFFF_9ABC_DEF0, 0, 64'h8, 64'h0, 8'h00);
        vecs[10] = mk(1, 0, 3'd6, 64'h8, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 1, 0,
                      3, 64'h9ABC_DEF0, 0, 64'h8, 64'h0, 8'h00);

        reset = 1'b1; memory_enable = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        alu_data = '0; reg_b_contents = '0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
        dc_resp_rdata = '0;
        repeat (2) @(negedge clk);
        reset_checks("reset");
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            if (i == 9) begin
                @(negedge clk);
                mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; alu_data = 64'h10;
                memory_enable = 1'b1; dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
                @(negedge clk);
                memory_enable = 1'b0;
                chk("prereset_valid", {63'b0, dc_req_valid}, 64'd1);
                dc_req_ready = 1'b1;
                @(negedge clk);
                dc_req_ready = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset_checks("midreset");
                reset = 1'b0;
                dc_resp_valid = 1'b1;
                @(negedge clk);
                dc_resp_valid = 1'b0;
                chk("postreset_idle", {62'b0, memory_done, dc_req_valid}, 64'd0);
            end
            run(vecs[i]);
        end

        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 9);
            run(model(r < 4 || r == 9, (r >= 4 && r < 8) || r == 9, 3'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

Parametrised memory-stage engine for the pipelined core: it takes one load/store per start pulse from the execute/memory pipeline register and issues it to the data cache over a valid/ready request channel. It waits for the cache response, then returns an aligned, sign- or zero-extended load result and a single-cycle `memory_done`. Non-memory instructions complete with fixed latency, and misaligned or illegal accesses complete with an error flag and no cache traffic.

## Interface
- `XLEN`, default 64: data width; legal values 32 or 64.
- `ADDR_W`, default 64: address width.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `memory_enable`  in  1  single-cycle start pulse; sampled only in IDLE.
- `mem_read`  in  1  instruction is a load.
- `mem_write`  in  1  instruction is a store.
- `funct3`  in  3  [1:0] size (0 B, 1 H, 2 W, 3 D); [2] unsigned load.
- `alu_data`  in  ADDR_W  effective address.
- `reg_b_contents`  in  XLEN  store data, right-justified.
- `loaded_data_out`  out  XLEN  extended load result; held until next start.
- `memory_done`  out  1  one-cycle completion pulse.
- `access_err`  out  1  valid with `memory_done`; misaligned or illegal access.
- `dc_req_valid`  out  1  cache request valid.
- `dc_req_ready`  in  1  cache accepts request.
- `dc_req_write`  out  1  1 = store.
- `dc_req_addr`  out  ADDR_W  address with low log2(XLEN/8) bits cleared.
- `dc_req_wdata`  out  XLEN  store data shifted to its byte lane.
- `dc_req_wstrb`  out  XLEN/8  byte strobes; all-zero for loads.
- `dc_resp_valid`  in  1  response or write ack.
- `dc_resp_rdata`  in  XLEN  full aligned word for loads.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE with `memory_enable`=1: latch all inputs. Compute lane = addr[log2(XLEN/8)-1:0] and nbytes = 1<<size.
  - Neither read nor write: go to DONE with `access_err`=0.
  - Both read and write, size 3 with XLEN=32, or addr not a multiple of nbytes: go to DONE with `access_err`=1 and no request.
  - Otherwise go to REQ.
- REQ: `dc_req_valid`=1. Request fields are stable and driven from registers until accepted. On `dc_req_ready`=1, go to WAIT.
- WAIT: `dc_resp_valid` is ignored in every other state. On `dc_resp_valid`=1:
  - Load: shift `dc_resp_rdata` right by lane*8, take the low nbytes*8 bits, then sign-extend (funct3[2]=0) or zero-extend, and register the result into `loaded_data_out`.
  - Store: `loaded_data_out`=0.
  - In both cases go to DONE.
- DONE: `memory_done`=1 for exactly one cycle, then go to IDLE.
- Store lane formatting:
  - `dc_req_wdata` = `reg_b_contents` << (lane*8).
  - `dc_req_wstrb` = ((1<<nbytes)-1) << lane.
- `memory_enable` outside IDLE is ignored and not queued.
- For non-load completions and error completions, `loaded_data_out`=0.

## Timing
- Reset: state IDLE. All outputs 0: `dc_req_valid`, `dc_req_write`, `dc_req_addr`, `dc_req_wdata`, `dc_req_wstrb`, `loaded_data_out`, `memory_done`, `access_err`.
- Reset mid-operation: the FSM returns to IDLE on the next edge, and any pending request is dropped. The cache is reset by the same signal, so no stale response follows.
- Non-memory or error path: start at cycle 0, `memory_done` at cycle 1.
- Memory path with ready and response both at the earliest point:
  - Start at cycle 0.
  - `dc_req_valid` at cycle 1, accepted at cycle 1.
  - Response at cycle 2.
  - `memory_done` at cycle 3.
- Each cycle of `dc_req_ready`=0 or response delay adds one cycle.
- `dc_resp_valid` in the same cycle as acceptance is not consumed. The cache guarantees a response no earlier than the cycle after acceptance.
- `loaded_data_out` and `access_err` change only on the edge entering DONE. `loaded_data_out` is stable from that edge until the next start.

## Test plan
- LB signed, XLEN=64:
  - Stimulus: addr=0x1003, rdata=0x1122_3344_8566_7788.
  - Required: byte 0x85 gives `loaded_data_out`=0xFFFF_FFFF_FFFF_FF85, with done at cycle 3 and `dc_req_addr`=0x1000.
  - Repeat as LBU: required result 0x85.
- SH:
  - Stimulus: addr=0x2006, `reg_b_contents`=0xABCD.
  - Required: `dc_req_wstrb`=0xC0, `dc_req_wdata`=0xABCD_0000_0000_0000, `dc_req_write`=1. Done one cycle after the ack.
- Misaligned LW at addr=0x3002:
  - Required: no `dc_req_valid` ever; `memory_done` and `access_err` at cycle 1.
  - Also cover: size 3 with XLEN=32 flags an error; read and write both set flags an error.
- Backpressure on LD:
  - Stimulus: `dc_req_ready` held low 4 cycles, response 3 cycles after acceptance.
  - Required: request fields stable while stalled, done at cycle 9. A `memory_enable` pulse while busy is ignored.
- Non-memory instruction: `memory_done` at cycle 1, `loaded_data_out`=0, no request.
- Reset asserted while in WAIT:
  - Required: all outputs 0 next cycle.
  - A fresh LW at addr=0x8 afterwards completes normally with the upper half zero/sign-extended.
